// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, state encoding and alignment helpers for the fetch sequencer.
// Every fetch address is a multiple of PC_STEP, so its low bits must be zero.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    VALID = 3'd2,
    FLUSH = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr & (PC_STEP - 1'b1)) != '0;
  endfunction

  function automatic logic [XLEN-1:0] force_align(input logic [XLEN-1:0] addr);
    return addr & ~(PC_STEP - 1'b1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of PC-register controls, imem fetch port, decode handshake and redirect inputs.
// The master side is the sequencer; the slave side is the PC register, imem and decode.
interface fetch_sequencer_if;
  import core_pkg::*;

  logic [XLEN-1:0]    PC;
  logic               A;
  logic               H;
  logic [XLEN-1:0]    PCin;
  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [XLEN-1:0]    instr_pc;
  logic               redirect_valid;
  logic               redirect_abs;
  logic [XLEN-1:0]    redirect_target;
  logic               fetch_fault;

  modport master (
    input  PC, imem_ack, imem_rdata, instr_ready,
           redirect_valid, redirect_abs, redirect_target,
    output A, H, PCin, imem_req, imem_addr,
           instr_valid, instr, instr_pc, fetch_fault
  );

  modport slave (
    output PC, imem_ack, imem_rdata, instr_ready,
           redirect_valid, redirect_abs, redirect_target,
    input  A, H, PCin, imem_req, imem_addr,
           instr_valid, instr, instr_pc, fetch_fault
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Sequences boot, instruction fetch, decode backpressure and redirects by steering the
// external PC register through A/H/PCin; the PC is explicitly held whenever it must not move.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR   = 32'h0000_0000,
  parameter bit              ALIGN_CHECK = 1'b1
) (
  input logic               Clock,
  input logic               nReset,
  fetch_sequencer_if.master bus
);

  fetch_state_t       state_q, state_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q;
  logic [XLEN-1:0]    instr_pc_q;
  logic               fault_q, fault_d;
  logic               load_buf;
  logic               redir_bad;
  logic               redir_ok;
  logic [XLEN-1:0]    redir_val;

  // A misaligned target is refused when checking is on; otherwise it is quietly word-aligned.
  assign redir_bad = ALIGN_CHECK && bus.redirect_valid && (state_q != FAULT)
                     && is_misaligned(bus.redirect_target);
  assign redir_ok  = bus.redirect_valid && !redir_bad && (state_q != FAULT);
  assign redir_val = ALIGN_CHECK ? bus.redirect_target : force_align(bus.redirect_target);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    fault_d  = fault_q | redir_bad;
    load_buf = 1'b0;
    case (state_q)
      BOOT: state_d = redir_bad ? FAULT : FETCH;
      FETCH: begin
        if (redir_bad || redir_ok) begin
          // An unacknowledged request must still run to completion at its original address.
          if (bus.imem_ack) begin
            state_d = redir_bad ? FAULT : FETCH;
          end else begin
            addr_d  = bus.PC;
            state_d = FLUSH;
          end
        end else if (bus.imem_ack) begin
          load_buf = 1'b1;
          state_d  = VALID;
        end
      end
      VALID: begin
        if (redir_bad) begin
          state_d = FAULT;
        end else if (redir_ok || bus.instr_ready) begin
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (bus.imem_ack) begin
          state_d = fault_d ? FAULT : FETCH;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= BOOT;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      addr_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      addr_q <= addr_d;
      if (load_buf) begin
        instr_q    <= bus.imem_rdata;
        instr_pc_q <= bus.PC;
      end
    end
  end

  // The PC register loads every cycle, so "no change" means H=1 with PCin=PC.
  always_comb begin
    bus.A    = 1'b0;
    bus.H    = 1'b1;
    bus.PCin = bus.PC;
    if (state_q == BOOT) begin
      bus.PCin = BOOT_ADDR;
    end
    if (load_buf) begin
      bus.A = 1'b1;
      bus.H = 1'b0;
    end
    if (redir_ok) begin
      bus.A    = 1'b0;
      bus.H    = bus.redirect_abs;
      bus.PCin = redir_val;
    end
  end

  assign bus.imem_req    = (state_q == FETCH) || (state_q == FLUSH);
  assign bus.imem_addr   = (state_q == FETCH) ? bus.PC :
                           (state_q == FLUSH) ? addr_q : '0;
  assign bus.instr_valid = (state_q == VALID);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer with a real PC register and an imem model whose ack delay is programmable.
// Expected values come from the architectural rules: sequential PCs, memWord(addr) contents, redirect targets.
module tb_fetch_sequencer;
  import core_pkg::*;

  logic Clock = 1'b0;
  logic nReset;
  fetch_sequencer_if bus();

  fetch_sequencer #(.BOOT_ADDR(32'h0), .ALIGN_CHECK(1'b1)) dut (
    .Clock (Clock),
    .nReset(nReset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;
  int ackDelay = 0;
  int reqCnt;
  int cyc = 0;
  int addrChanges = 0;
  int reqDrops = 0;
  int instrChanges = 0;
  logic [31:0] pcReg;
  logic pend = 1'b0;
  logic [31:0] pendAddr;
  logic heldValid = 1'b0;
  logic [31:0] heldInstr, heldPc;
  logic [31:0] fetchLog[$];
  logic [31:0] accPc[$];
  logic [31:0] accInstr[$];
  int accCyc[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) pcReg <= 32'h0;
    else if (bus.H) pcReg <= bus.PCin;
    else if (bus.A) pcReg <= pcReg + 32'd4;
    else pcReg <= pcReg + bus.PCin;
  end
  assign bus.PC = pcReg;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) reqCnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) reqCnt <= reqCnt + 1;
    else reqCnt <= 0;
  end
  assign bus.imem_ack   = bus.imem_req && (reqCnt >= ackDelay);
  assign bus.imem_rdata = memWord(bus.imem_addr);

  // Protocol monitor: logs completed fetches and decode transfers, counts stability violations.
  always @(negedge Clock) begin
    if (!nReset) begin
      pend = 1'b0;
      heldValid = 1'b0;
    end else begin
      cyc++;
      if (bus.imem_req) begin
        if (pend && bus.imem_addr !== pendAddr) addrChanges++;
        if (bus.imem_ack) begin
          fetchLog.push_back(bus.imem_addr);
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          pendAddr = bus.imem_addr;
        end
      end else begin
        if (pend) reqDrops++;
        pend = 1'b0;
      end
      if (bus.instr_valid) begin
        if (heldValid && (bus.instr !== heldInstr || bus.instr_pc !== heldPc)) instrChanges++;
        heldValid = !bus.instr_ready;
        heldInstr = bus.instr;
        heldPc = bus.instr_pc;
        if (bus.instr_ready) begin
          accPc.push_back(bus.instr_pc);
          accInstr.push_back(bus.instr);
          accCyc.push_back(cyc);
        end
      end else begin
        heldValid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clearLogs();
    fetchLog.delete();
    accPc.delete();
    accInstr.delete();
    accCyc.delete();
    addrChanges = 0;
    reqDrops = 0;
    instrChanges = 0;
  endtask

  task automatic doReset();
    nReset = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_abs = 1'b0;
    bus.redirect_target = 32'h0;
    repeat (2) @(posedge Clock);
    #1;
    clearLogs();
    nReset = 1'b1;
  endtask

  task automatic waitAccepts(input int n, input int budget, input string tag);
    int c = 0;
    while (accPc.size() < n && c < budget) begin
      step();
      c++;
    end
    total++;
    if (accPc.size() < n) begin
      bad++;
      $display("FAIL %s_timeout: accepted=%0d need=%0d", tag, accPc.size(), n);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_abs = 1'b0;
    bus.redirect_target = 32'h0;
    ackDelay = 0;
    repeat (2) step();
    total += 9;
    if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %0b want 0", bus.imem_req); end
    if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", bus.instr_valid); end
    if (bus.instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", bus.instr); end
    if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc: got %h want 0", bus.instr_pc); end
    if (bus.fetch_fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %0b want 0", bus.fetch_fault); end
    if (bus.H !== 1'b1) begin bad++; $display("FAIL rst_H: got %0b want 1", bus.H); end
    if (bus.A !== 1'b0) begin bad++; $display("FAIL rst_A: got %0b want 0", bus.A); end
    if (bus.PCin !== 32'h0) begin bad++; $display("FAIL rst_PCin: got %h want 0", bus.PCin); end
    if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr); end
    clearLogs();
    bus.instr_ready = 1'b1;
    nReset = 1'b1;
    #1;
    total += 3;
    if (bus.H !== 1'b1) begin bad++; $display("FAIL boot_H: got %0b want 1", bus.H); end
    if (bus.PCin !== 32'h0) begin bad++; $display("FAIL boot_PCin: got %h want 0", bus.PCin); end
    if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL boot_req: got %0b want 0", bus.imem_req); end
    step();
    total += 2;
    if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL first_req: got %0b want 1", bus.imem_req); end
    if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_basic();
    waitAccepts(4, 20, "basic");
    for (int k = 0; k < 4; k++) begin
      total += 2;
      if (accPc[k] !== 32'(4 * k)) begin bad++; $display("FAIL basic_pc%0d: got %h want %h", k, accPc[k], 32'(4 * k)); end
      if (accInstr[k] !== memWord(32'(4 * k))) begin bad++; $display("FAIL basic_instr%0d: got %h want %h", k, accInstr[k], memWord(32'(4 * k))); end
      if (k > 0) begin
        total++;
        if (accCyc[k] - accCyc[k-1] !== 2) begin bad++; $display("FAIL basic_rate%0d: got %0d cycles want 2", k, accCyc[k] - accCyc[k-1]); end
      end
    end
  endtask

  task automatic test_stall();
    bit seen = 1'b0;
    ackDelay = 3;
    doReset();
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.instr_valid) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL stall_valid_timeout: got 0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      total += 5;
      if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid%0d: got %0b want 1", i, bus.instr_valid); end
      if (bus.instr !== memWord(32'h0)) begin bad++; $display("FAIL stall_instr%0d: got %h want %h", i, bus.instr, memWord(32'h0)); end
      if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL stall_ipc%0d: got %h want 0", i, bus.instr_pc); end
      if (bus.PC !== 32'h4) begin bad++; $display("FAIL stall_pc%0d: got %h want 4", i, bus.PC); end
      if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req%0d: got %0b want 0", i, bus.imem_req); end
      step();
    end
    bus.instr_ready = 1'b1;
    waitAccepts(2, 20, "stall");
    total += 4;
    if (accPc[1] !== 32'h4) begin bad++; $display("FAIL stall_next_pc: got %h want 4", accPc[1]); end
    if (addrChanges !== 0) begin bad++; $display("FAIL stall_addr_stable: got %0d changes want 0", addrChanges); end
    if (instrChanges !== 0) begin bad++; $display("FAIL stall_instr_stable: got %0d changes want 0", instrChanges); end
    if (reqDrops !== 0) begin bad++; $display("FAIL stall_req_drop: got %0d want 0", reqDrops); end
  endtask

  task automatic test_random();
    int c = 0;
    doReset();
    while (accPc.size() < 24 && c < 2000) begin
      ackDelay = int'($urandom_range(0, 4));
      bus.instr_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    total++;
    if (accPc.size() < 24) begin bad++; $display("FAIL rand_timeout: accepted=%0d need=24", accPc.size()); end
    for (int k = 0; k < 24; k++) begin
      total += 2;
      if (accPc[k] !== 32'(4 * k)) begin bad++; $display("FAIL rand_pc%0d: got %h want %h", k, accPc[k], 32'(4 * k)); end
      if (accInstr[k] !== memWord(32'(4 * k))) begin bad++; $display("FAIL rand_instr%0d: got %h want %h", k, accInstr[k], memWord(32'(4 * k))); end
    end
    total += 3;
    if (addrChanges !== 0) begin bad++; $display("FAIL rand_addr_stable: got %0d want 0", addrChanges); end
    if (instrChanges !== 0) begin bad++; $display("FAIL rand_instr_stable: got %0d want 0", instrChanges); end
    if (reqDrops !== 0) begin bad++; $display("FAIL rand_req_drop: got %0d want 0", reqDrops); end
  endtask

  task automatic test_redirect_abs();
    ackDelay = 4;
    doReset();
    bus.instr_ready = 1'b1;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_abs = 1'b1;
    bus.redirect_target = 32'h100;
    #1;
    total += 3;
    if (bus.imem_req !== 1'b1 || bus.imem_ack !== 1'b0) begin bad++; $display("FAIL rabs_wait: req=%0b ack=%0b want 1/0", bus.imem_req, bus.imem_ack); end
    if (bus.H !== 1'b1) begin bad++; $display("FAIL rabs_H: got %0b want 1", bus.H); end
    if (bus.PCin !== 32'h100) begin bad++; $display("FAIL rabs_PCin: got %h want 100", bus.PCin); end
    step();
    bus.redirect_valid = 1'b0;
    total += 3;
    if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rabs_flush_req: got %0b want 1", bus.imem_req); end
    if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rabs_flush_addr: got %h want 0", bus.imem_addr); end
    if (bus.PC !== 32'h100) begin bad++; $display("FAIL rabs_pc: got %h want 100", bus.PC); end
    waitAccepts(1, 40, "rabs");
    total += 6;
    if (fetchLog.size() < 2) begin bad++; $display("FAIL rabs_fetch_count: got %0d want >=2", fetchLog.size()); end
    if (fetchLog[0] !== 32'h0) begin bad++; $display("FAIL rabs_fetch0: got %h want 0", fetchLog[0]); end
    if (fetchLog[1] !== 32'h100) begin bad++; $display("FAIL rabs_fetch1: got %h want 100", fetchLog[1]); end
    if (accPc[0] !== 32'h100) begin bad++; $display("FAIL rabs_acc_pc: got %h want 100", accPc[0]); end
    if (accInstr[0] !== memWord(32'h100)) begin bad++; $display("FAIL rabs_acc_instr: got %h want %h", accInstr[0], memWord(32'h100)); end
    if (addrChanges !== 0 || reqDrops !== 0) begin bad++; $display("FAIL rabs_protocol: changes=%0d drops=%0d want 0/0", addrChanges, reqDrops); end
  endtask

  task automatic test_redirect_rel();
    bit seen = 1'b0;
    ackDelay = 0;
    doReset();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.instr_valid && bus.instr_pc == 32'h1C) begin
        bus.instr_ready = 1'b0;
        seen = 1'b1;
        break;
      end
    end
    total += 3;
    if (!seen) begin bad++; $display("FAIL rrel_reach: got instr_pc %h want 1c", bus.instr_pc); end
    if (bus.PC !== 32'h20) begin bad++; $display("FAIL rrel_pc_before: got %h want 20", bus.PC); end
    if (accPc.size() !== 7) begin bad++; $display("FAIL rrel_acc_before: got %0d want 7", accPc.size()); end
    bus.redirect_valid = 1'b1;
    bus.redirect_abs = 1'b0;
    bus.redirect_target = 32'hFFFF_FFF8;
    #1;
    total += 3;
    if (bus.H !== 1'b0) begin bad++; $display("FAIL rrel_H: got %0b want 0", bus.H); end
    if (bus.A !== 1'b0) begin bad++; $display("FAIL rrel_A: got %0b want 0", bus.A); end
    if (bus.PCin !== 32'hFFFF_FFF8) begin bad++; $display("FAIL rrel_PCin: got %h want fffffff8", bus.PCin); end
    step();
    bus.redirect_valid = 1'b0;
    total += 4;
    if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rrel_valid_drop: got %0b want 0", bus.instr_valid); end
    if (bus.PC !== 32'h18) begin bad++; $display("FAIL rrel_pc_after: got %h want 18", bus.PC); end
    if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rrel_req: got %0b want 1", bus.imem_req); end
    if (bus.imem_addr !== 32'h18) begin bad++; $display("FAIL rrel_addr: got %h want 18", bus.imem_addr); end
    bus.instr_ready = 1'b1;
    waitAccepts(8, 20, "rrel");
    total++;
    if (accPc[7] !== 32'h18) begin bad++; $display("FAIL rrel_acc_after: got %h want 18", accPc[7]); end
  endtask

  task automatic test_fault();
    bit acked = 1'b0;
    ackDelay = 3;
    doReset();
    bus.instr_ready = 1'b1;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_abs = 1'b1;
    bus.redirect_target = 32'h102;
    #1;
    total += 2;
    if (bus.H !== 1'b1) begin bad++; $display("FAIL fault_H: got %0b want 1", bus.H); end
    if (bus.PCin !== 32'h0) begin bad++; $display("FAIL fault_PCin: got %h want 0", bus.PCin); end
    step();
    bus.redirect_valid = 1'b0;
    total += 4;
    if (bus.fetch_fault !== 1'b1) begin bad++; $display("FAIL fault_flag: got %0b want 1", bus.fetch_fault); end
    if (bus.PC !== 32'h0) begin bad++; $display("FAIL fault_pc: got %h want 0", bus.PC); end
    if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL fault_outstanding_req: got %0b want 1", bus.imem_req); end
    if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL fault_outstanding_addr: got %h want 0", bus.imem_addr); end
    for (int i = 0; i < 10; i++) begin
      if (fetchLog.size() > 0) begin acked = 1'b1; break; end
      step();
    end
    total++;
    if (!acked) begin bad++; $display("FAIL fault_ack_timeout: got 0 acks want 1"); end
    for (int i = 0; i < 8; i++) begin
      total += 4;
      if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL fault_hold_req%0d: got %0b want 0", i, bus.imem_req); end
      if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL fault_hold_valid%0d: got %0b want 0", i, bus.instr_valid); end
      if (bus.fetch_fault !== 1'b1) begin bad++; $display("FAIL fault_hold_flag%0d: got %0b want 1", i, bus.fetch_fault); end
      if (bus.PC !== 32'h0) begin bad++; $display("FAIL fault_hold_pc%0d: got %h want 0", i, bus.PC); end
      bus.instr_ready = 1'($urandom_range(0, 1));
      step();
    end
    total += 2;
    if (reqDrops !== 0) begin bad++; $display("FAIL fault_req_drop: got %0d want 0", reqDrops); end
    if (accPc.size() !== 0) begin bad++; $display("FAIL fault_no_accept: got %0d want 0", accPc.size()); end
    doReset();
    total++;
    if (bus.fetch_fault !== 1'b0) begin bad++; $display("FAIL fault_cleared: got %0b want 0", bus.fetch_fault); end
  endtask

  task automatic test_wrap();
    ackDelay = 0;
    doReset();
    bus.instr_ready = 1'b1;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_abs = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    waitAccepts(2, 20, "wrap");
    total += 6;
    if (fetchLog.size() < 3) begin bad++; $display("FAIL wrap_fetch_count: got %0d want >=3", fetchLog.size()); end
    if (fetchLog[1] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_fetch1: got %h want fffffffc", fetchLog[1]); end
    if (fetchLog[2] !== 32'h0) begin bad++; $display("FAIL wrap_fetch2: got %h want 0", fetchLog[2]); end
    if (accPc[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_acc0: got %h want fffffffc", accPc[0]); end
    if (accInstr[0] !== memWord(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_instr0: got %h want %h", accInstr[0], memWord(32'hFFFF_FFFC)); end
    if (accPc[1] !== 32'h0 || bus.fetch_fault !== 1'b0) begin bad++; $display("FAIL wrap_acc1: got pc %h fault %0b want 0/0", accPc[1], bus.fetch_fault); end
  endtask

  task automatic test_reset_mid_fetch();
    bit found = 1'b0;
    ackDelay = 3;
    doReset();
    bus.instr_ready = 1'b1;
    waitAccepts(2, 30, "midrst");
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_req && !bus.imem_ack) begin found = 1'b1; break; end
      step();
    end
    total++;
    if (!found) begin bad++; $display("FAIL midrst_no_wait: got req=%0b want waiting fetch", bus.imem_req); end
    #2;
    nReset = 1'b0;
    #1;
    total += 8;
    if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL midrst_req: got %0b want 0", bus.imem_req); end
    if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", bus.instr_valid); end
    if (bus.instr !== 32'h0) begin bad++; $display("FAIL midrst_instr: got %h want 0", bus.instr); end
    if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL midrst_ipc: got %h want 0", bus.instr_pc); end
    if (bus.fetch_fault !== 1'b0) begin bad++; $display("FAIL midrst_fault: got %0b want 0", bus.fetch_fault); end
    if (bus.H !== 1'b1 || bus.A !== 1'b0) begin bad++; $display("FAIL midrst_HA: got H=%0b A=%0b want 1/0", bus.H, bus.A); end
    if (bus.PCin !== 32'h0) begin bad++; $display("FAIL midrst_PCin: got %h want 0", bus.PCin); end
    if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_addr: got %h want 0", bus.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_redirect_abs();
    test_redirect_rel();
    test_fault();
    test_wrap();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
